lease_arbiter4: RTL and testbench

Round-robin arbiter that leases one shared resource to one of four requesters at a time.
- The owner holds the grant until it releases, drops its request, or exceeds a maximum lease length.
- A timeout forcibly revokes the grant and reports the event.
- Sits alongside the request/grant queueing arbiter and provides fair, bounded-hold access to a single shared datapath resource.

---
 rtl/arb_pkg.sv | 9 +
 rtl/rr_pick4.sv | 18 +
 rtl/lease_arbiter4.sv | 78 +++++++
 tb/tb_lease_arbiter4.sv | 114 +++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared types and helpers for the lease arbiter
package arb_pkg;
    localparam int N_REQ = 4;
    localparam int ID_W = 2;
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, RECOVER = 2'd2} state_t;
    function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: rotating priority encoder, first request at or after ptr
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             valid,
    output logic [ID_W-1:0]  idx
);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [ID_W-1:0]    off;
    assign dbl = {req, req};
    assign rot = dbl[ptr +: N_REQ];
    assign off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    assign valid = |req;
    assign idx = ptr + off;
endmodule

// File: rtl/lease_arbiter4.sv
// lease_arbiter4: round-robin arbiter granting a bounded-length lease on one resource
module lease_arbiter4
    import arb_pkg::*;
#(
    parameter int MAX_LEASE = 15,
    parameter int LEASE_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] request,
    input  logic [N_REQ-1:0] release_req,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  owner_id,
    output logic             busy,
    output logic             timeout
);
    state_t             state, state_n;
    logic [ID_W-1:0]    ptr, ptr_n, owner_n, pick_idx;
    logic [LEASE_W-1:0] cnt, cnt_n;
    logic [N_REQ-1:0]   grant_n;
    logic               timeout_n, pick_valid, done, expire, leave;
    rr_pick4 u_pick (
        .req   (request),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );
    assign done = release_req[owner_id] | ~request[owner_id];
    assign expire = cnt == LEASE_W'(MAX_LEASE - 1);
    assign leave = done | expire;
    assign busy = |grant;
    // next-state: arbitrate when free, count and end the lease when granted
    always_comb begin
        state_n = state;
        ptr_n = ptr;
        cnt_n = cnt;
        grant_n = grant;
        owner_n = owner_id;
        timeout_n = 1'b0;
        case (state)
            IDLE, RECOVER: begin
                state_n = pick_valid ? GRANT : IDLE;
                grant_n = pick_valid ? onehot(pick_idx) : '0;
                owner_n = pick_valid ? pick_idx : owner_id;
                cnt_n = '0;
            end
            GRANT: begin
                state_n = leave ? RECOVER : GRANT;
                grant_n = leave ? '0 : grant;
                ptr_n = leave ? owner_id + 2'd1 : ptr;
                cnt_n = leave ? cnt : cnt + 1'b1;
                timeout_n = expire & ~done;
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end
    // state and registered outputs, cleared asynchronously
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ptr <= '0;
            cnt <= '0;
            grant <= '0;
            owner_id <= '0;
            timeout <= 1'b0;
        end else begin
            state <= state_n;
            ptr <= ptr_n;
            cnt <= cnt_n;
            grant <= grant_n;
            owner_id <= owner_n;
            timeout <= timeout_n;
        end
    end
endmodule

// File: tb/tb_lease_arbiter4.sv
// tb_lease_arbiter4: randomized check of lease_arbiter4 against a behavioural model
module tb_lease_arbiter4;
    localparam int MAX_LEASE = 15;
    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] request, release_req, grant;
    logic [1:0] owner_id;
    logic       busy, timeout;
    int tests = 0, fails = 0;
    int m_owner, m_last, m_held, m_ptr, m_to, timeouts_seen;
    lease_arbiter4 #(.MAX_LEASE(MAX_LEASE), .LEASE_W(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .request     (request),
        .release_req (release_req),
        .grant       (grant),
        .owner_id    (owner_id),
        .busy        (busy),
        .timeout     (timeout)
    );
    always #5 clock = ~clock;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        m_owner = -1;
        m_last = 0;
        m_held = 0;
        m_ptr = 0;
        m_to = 0;
    endtask
    task automatic model_step(input logic [3:0] req, input logic [3:0] rel);
        if (m_owner >= 0) begin
            if (rel[m_owner] || !req[m_owner] || m_held == MAX_LEASE) begin
                m_to = (rel[m_owner] || !req[m_owner]) ? 0 : 1;
                m_ptr = (m_owner + 1) % 4;
                m_owner = -1;
            end else m_held++;
        end else begin
            m_to = 0;
            for (int k = 0; k < 4; k++)
                if (m_owner < 0 && req[(m_ptr + k) % 4]) begin
                    m_owner = (m_ptr + k) % 4;
                    m_last = m_owner;
                    m_held = 1;
                end
        end
    endtask
    task automatic check_all();
        chk("grant", grant, m_owner >= 0 ? 32'(1 << m_owner) : 32'd0);
        chk("owner_id", owner_id, m_last);
        chk("busy", busy, m_owner >= 0);
        chk("timeout", timeout, m_to);
        if (m_to != 0) timeouts_seen++;
    endtask
    task automatic cycle(input logic [3:0] req, input logic [3:0] rel);
        request = req;
        release_req = rel;
        @(posedge clock);
        model_step(req, rel);
        @(negedge clock);
        check_all();
    endtask
    initial begin
        logic [3:0] req_r, rel_r;
        timeouts_seen = 0;
        reset = 1'b1;
        request = '0;
        release_req = '0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        check_all();
        reset = 1'b0;
        req_r = 4'b0001;
        for (int i = 0; i < 12; i++)
            cycle(req_r, (m_owner >= 0 && m_held == 3) ? 4'b0001 : 4'b0000);
        for (int i = 0; i < 20; i++)
            cycle(4'b1111, (m_owner >= 0 && m_held == 2) ? 4'(1 << m_owner) : 4'b0000);
        for (int i = 0; i < 40; i++) cycle(4'b0100, 4'b0000);
        for (int i = 0; i < 80; i++) begin
            rel_r = 4'($urandom_range(15));
            if (m_owner >= 0) rel_r = (m_held == MAX_LEASE) ? (rel_r | 4'(1 << m_owner)) : (rel_r & ~4'(1 << m_owner));
            cycle(4'b1111, rel_r);
        end
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(15) == 0) req_r[b] = ~req_r[b];
                rel_r[b] = $urandom_range(9) == 0;
            end
            cycle(req_r, rel_r);
        end
        for (int i = 0; i < 30 && !(m_owner >= 0 && m_held == 5); i++) cycle(4'b1111, 4'b0000);
        chk("reach_lease5", busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("async_grant", grant, 4'b0000);
        chk("async_busy", busy, 1'b0);
        chk("async_timeout", timeout, 1'b0);
        model_reset();
        request = 4'b1010;
        release_req = 4'b0000;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) cycle(4'b1010, 4'b0000);
        chk("timeouts_seen_nonzero", timeouts_seen != 0, 1'b1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
